// File: rtl/wram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wram_arbiter
// Purpose  : Shares one single-port 8 KB work-RAM between a CPU bus (byte
//            strobes, fixed latency) and an RV bus (toggle handshake, 16-bit
//            data with byte strobes). CPU accesses are issued in the strobe
//            cycle and preempt RV; a colliding RV request is latched and
//            issued the following cycle.
// Ports    : clk, resetn (async, active-low)
//            cpu_addr/cpu_we/cpu_oe/cpu_din -> cpu_dout, cpu_hit
//            rv_addr/rv_din/rv_ds/rv_we/rv_req -> rv_dout, rv_ack, rv_hit
//            i_wram_load_ongoing : RV owns the RAM, CPU writes dropped,
//                                  CPU reads return 8'hFF
//            mem_addr/mem_we/mem_din/mem_dout : BSRAM port (1-cycle read)
//            dirty_clr -> dirty  : CPU write tracking
// Config   : WRAM_DIRTY_TRACK_EN enables dirty tracking; when undefined
//            dirty is tied low and dirty_clr is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module wram_arbiter #(
    parameter logic [15:0] CPU_BASE = 16'h6000,
    parameter logic [22:0] RV_BASE  = 23'h066000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_we,
    input  logic        cpu_oe,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_hit,
    input  logic [22:0] rv_addr,
    input  logic [15:0] rv_din,
    input  logic [1:0]  rv_ds,
    input  logic        rv_we,
    input  logic        rv_req,
    output logic [15:0] rv_dout,
    output logic        rv_ack,
    output logic        rv_hit,
    input  logic        i_wram_load_ongoing,
    output logic [12:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout,
    input  logic        dirty_clr,
    output logic        dirty
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RV_WAIT = 2'd1;
    localparam logic [1:0] S_RV_RD   = 2'd2;
    localparam logic [1:0] S_RV_ACK  = 2'd3;

    // Upper window limits computed one bit wider so a base near the top of
    // the address space cannot wrap.
    localparam logic [16:0] CPU_LIM = {1'b0, CPU_BASE} + 17'h01FFF;
    localparam logic [23:0] RV_LIM  = {1'b0, RV_BASE}  + 24'h001FFF;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic        r_armed;
    logic        r_req_q;
    logic [12:0] r_lat_idx;
    logic [15:0] r_lat_din;
    logic [1:0]  r_lat_ds;
    logic        r_lat_we;
    logic        r_cpu_rd;
    logic        r_cpu_rd_ff;

    logic [12:0] w_cpu_idx;
    logic [12:0] w_rv_idx;
    logic        w_cpu_issue;
    logic        w_rv_det;
    logic        w_rv_live;
    logic        w_rv_lat;

    assign cpu_hit = ({1'b0, cpu_addr} >= {1'b0, CPU_BASE}) && ({1'b0, cpu_addr} <= CPU_LIM);
    assign rv_hit  = ({1'b0, rv_addr}  >= {1'b0, RV_BASE})  && ({1'b0, rv_addr}  <= RV_LIM);

    // Window is 8 KB, so the index only depends on the low 13 address bits.
    assign w_cpu_idx = cpu_addr[12:0] - CPU_BASE[12:0];
    assign w_rv_idx  = rv_addr[12:0]  - RV_BASE[12:0];

    // resetn gates the combinational CPU path so the RAM port is quiet
    // while reset is held, even if the CPU bus is strobing.
    assign w_cpu_issue = resetn & (cpu_we | cpu_oe) & cpu_hit & ~i_wram_load_ongoing;
    assign w_rv_det    = (r_state == S_IDLE) & r_armed & (rv_req != r_req_q) & rv_hit;
    assign w_rv_live   = w_rv_det & ~w_cpu_issue;
    assign w_rv_lat    = (r_state == S_RV_WAIT) & ~w_cpu_issue;

    function automatic logic [7:0] rv_byte(input logic [15:0] d, input logic [1:0] ds);
        return ds[0] ? d[7:0] : d[15:8];
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_rv_det) begin
                    if (w_cpu_issue) w_state_next = S_RV_WAIT;
                    else             w_state_next = rv_we ? S_RV_ACK : S_RV_RD;
                end
            end
            S_RV_WAIT: begin
                if (!w_cpu_issue) w_state_next = r_lat_we ? S_RV_ACK : S_RV_RD;
            end
            S_RV_RD:  w_state_next = S_IDLE;
            S_RV_ACK: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: RAM port outputs ----------------
    always_comb begin
        mem_addr = 13'd0;
        mem_we   = 1'b0;
        mem_din  = 8'd0;
        if (w_cpu_issue) begin
            mem_addr = w_cpu_idx;
            mem_we   = cpu_we;
            mem_din  = cpu_we ? cpu_din : 8'd0;
        end else if (w_rv_live) begin
            mem_addr = w_rv_idx;
            mem_we   = rv_we & (|rv_ds);
            mem_din  = rv_byte(rv_din, rv_ds);
        end else if (w_rv_lat) begin
            mem_addr = r_lat_idx;
            mem_we   = r_lat_we & (|r_lat_ds);
            mem_din  = rv_byte(r_lat_din, r_lat_ds);
        end
    end

    // ---------------- Handshake, latch and read-data registers ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_armed     <= 1'b0;
            r_req_q     <= 1'b0;
            r_lat_idx   <= 13'd0;
            r_lat_din   <= 16'd0;
            r_lat_ds    <= 2'd0;
            r_lat_we    <= 1'b0;
            rv_ack      <= 1'b0;
            rv_dout     <= 16'd0;
            r_cpu_rd    <= 1'b0;
            r_cpu_rd_ff <= 1'b0;
            cpu_dout    <= 8'd0;
        end else begin
            // Toggle history only advances in IDLE so a toggle seen while
            // busy is still pending on return.
            if (r_state == S_IDLE) begin
                r_armed <= 1'b1;
                r_req_q <= rv_req;
            end
            if (w_rv_det) begin
                r_lat_idx <= w_rv_idx;
                r_lat_din <= rv_din;
                r_lat_ds  <= rv_ds;
                r_lat_we  <= rv_we;
            end
            // Write ack shows while in RV_ACK; read ack follows RV_RD.
            rv_ack <= (w_state_next == S_RV_ACK) | (r_state == S_RV_RD);
            if (r_state == S_RV_RD) begin
                rv_dout <= {mem_dout, mem_dout};
            end
            r_cpu_rd    <= cpu_oe & cpu_hit;
            r_cpu_rd_ff <= i_wram_load_ongoing;
            if (r_cpu_rd) begin
                cpu_dout <= r_cpu_rd_ff ? 8'hFF : mem_dout;
            end
        end
    end

`ifdef WRAM_DIRTY_TRACK_EN
    logic r_dirty;
    // A committed write in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dirty <= 1'b0;
        end else if (w_cpu_issue & cpu_we) begin
            r_dirty <= 1'b1;
        end else if (dirty_clr) begin
            r_dirty <= 1'b0;
        end
    end
    assign dirty = r_dirty;
`else
    logic w_unused_dirty_clr;
    assign w_unused_dirty_clr = dirty_clr;
    assign dirty = 1'b0;
`endif

endmodule
`default_nettype wire
